ps2_host_tx: RTL

Host-to-device PS/2 transmitter. Sends command bytes to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable. It shares the open-drain PS2_CLOCK/PS2_DATA pins with the existing keyboard receiver and runs on CLOCK_33. It drives the pins low only through output-enables; top-level tristate buffers pull each line low when its oe is 1. While busy is high, the receiver ignores the bus.

---
 rtl/ps2_pkg.sv | 33 +++
 rtl/ps2_line_filter.sv | 51 +++++
 rtl/ps2_host_tx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host-to-device transmitter.
package ps2_pkg;

    // Transmitter sequencing states
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INHIBIT   = 4'd1,
        ST_SETUP     = 4'd2,
        ST_RTS       = 4'd3,
        ST_DATA      = 4'd4,
        ST_STOP      = 4'd5,
        ST_ACK       = 4'd6,
        ST_WAIT_IDLE = 4'd7,
        ST_ERR       = 4'd8
    } ps2_tx_state_t;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    // Round a microsecond duration up to whole system-clock cycles
    function automatic logic [31:0] us_to_cycles(input longint unsigned freq,
                                                 input longint unsigned us);
        longint unsigned c;
        c = (freq * us + 64'd999_999) / 64'd1_000_000;
        return c[31:0];
    endfunction

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd
    function automatic logic odd_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes one raw PS/2 pin and debounces it: the filtered level only
// follows the pin after FILTER_LEN identical synchronized samples.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          fall_r;
    logic [CW-1:0] cnt_r;

    // Two-flop synchronizer feeding a stability counter; idle bus level is 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            level_r <= 1'b1;
            fall_r  <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else begin
            sync1_r <= pin;
            sync2_r <= sync1_r;
            fall_r  <= 1'b0;
            if (sync2_r == level_r) begin
                cnt_r <= CNT_ZERO;
            end else if (cnt_r == CNT_LAST) begin
                cnt_r   <= CNT_ZERO;
                level_r <= sync2_r;
                // leaving a high level means the line just fell
                fall_r  <= level_r;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign level = level_r;
    assign fall  = fall_r;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. Pulls the shared open-drain
// clock/data lines low only through output-enables; the device supplies
// the clock once the host has issued request-to-send.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_FREQ         = 33_333_333,
    parameter int INHIBIT_US       = 120,
    parameter int START_TIMEOUT_US = 15000,
    parameter int XFER_TIMEOUT_US  = 2000,
    parameter int FILTER_LEN       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam logic [31:0] INHIBIT_LAST =
        us_to_cycles(64'(CLK_FREQ), 64'(INHIBIT_US)) - 32'd1;
    localparam logic [31:0] SETUP_LAST =
        us_to_cycles(64'(CLK_FREQ), 64'd1) - 32'd1;
    localparam logic [31:0] START_LAST =
        us_to_cycles(64'(CLK_FREQ), 64'(START_TIMEOUT_US)) - 32'd1;
    localparam logic [31:0] XFER_LAST =
        us_to_cycles(64'(CLK_FREQ), 64'(XFER_TIMEOUT_US)) - 32'd1;

    ps2_tx_state_t              state_r;
    logic [31:0]                timer_r;
    logic [3:0]                 bit_idx_r;
    logic [PS2_FRAME_BITS-3:0]  frame_r;
    logic                       nack_r;
    logic                       clk_oe_r;
    logic                       data_oe_r;
    logic                       ready_r;
    logic                       busy_r;
    logic                       done_r;
    logic                       error_r;

    logic clk_level_s;
    logic clk_fall_s;
    logic data_level_s;
    // data edges carry no meaning for the host; only the level is sampled
    logic unused_data_fall_s;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .pin   (ps2_clk_in),
        .level (clk_level_s),
        .fall  (clk_fall_s)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .reset (reset),
        .pin   (ps2_data_in),
        .level (data_level_s),
        .fall  (unused_data_fall_s)
    );

    // Frame sequencer: inhibit, request-to-send, shift bits on device falls,
    // check the ack, then wait for the bus to go idle before reporting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            timer_r   <= 32'd0;
            bit_idx_r <= 4'd0;
            frame_r   <= {(PS2_FRAME_BITS-2){1'b0}};
            nack_r    <= 1'b0;
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    clk_oe_r  <= 1'b0;
                    data_oe_r <= 1'b0;
                    if (tx_valid && ready_r) begin
                        frame_r  <= {odd_parity(tx_data), tx_data};
                        timer_r  <= 32'd0;
                        clk_oe_r <= 1'b1;
                        ready_r  <= 1'b0;
                        busy_r   <= 1'b1;
                        state_r  <= ST_INHIBIT;
                    end else begin
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                ST_INHIBIT: begin
                    if (timer_r == INHIBIT_LAST) begin
                        timer_r   <= 32'd0;
                        data_oe_r <= 1'b1;   // start bit, driven before clock release
                        state_r   <= ST_SETUP;
                    end else begin
                        timer_r <= timer_r + 32'd1;
                    end
                end
                ST_SETUP: begin
                    if (timer_r == SETUP_LAST) begin
                        timer_r  <= 32'd0;
                        clk_oe_r <= 1'b0;
                        state_r  <= ST_RTS;
                    end else begin
                        timer_r <= timer_r + 32'd1;
                    end
                end
                ST_RTS: begin
                    if (clk_fall_s) begin
                        timer_r   <= 32'd0;
                        bit_idx_r <= 4'd0;
                        data_oe_r <= ~frame_r[0];
                        state_r   <= ST_DATA;
                    end else if (timer_r == START_LAST) begin
                        clk_oe_r  <= 1'b0;
                        data_oe_r <= 1'b0;
                        error_r   <= 1'b1;
                        state_r   <= ST_ERR;
                    end else begin
                        timer_r <= timer_r + 32'd1;
                    end
                end
                ST_DATA, ST_STOP, ST_ACK, ST_WAIT_IDLE: begin
                    if (timer_r == XFER_LAST) begin
                        clk_oe_r  <= 1'b0;
                        data_oe_r <= 1'b0;
                        error_r   <= 1'b1;
                        state_r   <= ST_ERR;
                    end else begin
                        timer_r <= timer_r + 32'd1;
                        if (state_r == ST_DATA) begin
                            if (clk_fall_s) begin
                                // falls 2..9 present bits 1..7 then parity
                                bit_idx_r <= bit_idx_r + 4'd1;
                                data_oe_r <= ~frame_r[bit_idx_r + 4'd1];
                                if (bit_idx_r == 4'd7) begin
                                    state_r <= ST_STOP;
                                end else begin
                                    state_r <= ST_DATA;
                                end
                            end else begin
                                data_oe_r <= data_oe_r;
                            end
                        end else if (state_r == ST_STOP) begin
                            if (clk_fall_s) begin
                                data_oe_r <= 1'b0;   // stop bit is the released line
                                state_r   <= ST_ACK;
                            end else begin
                                data_oe_r <= data_oe_r;
                            end
                        end else if (state_r == ST_ACK) begin
                            if (clk_fall_s) begin
                                nack_r  <= data_level_s;
                                state_r <= ST_WAIT_IDLE;
                            end else begin
                                nack_r <= nack_r;
                            end
                        end else begin
                            if (clk_level_s && data_level_s) begin
                                done_r  <= ~nack_r;
                                error_r <= nack_r;
                                ready_r <= 1'b1;
                                busy_r  <= 1'b0;
                                state_r <= ST_IDLE;
                            end else begin
                                state_r <= ST_WAIT_IDLE;
                            end
                        end
                    end
                end
                ST_ERR: begin
                    clk_oe_r  <= 1'b0;
                    data_oe_r <= 1'b0;
                    ready_r   <= 1'b1;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    clk_oe_r  <= 1'b0;
                    data_oe_r <= 1'b0;
                    ready_r   <= 1'b1;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready    = ready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign error       = error_r;
    assign ps2_clk_oe  = clk_oe_r;
    assign ps2_data_oe = data_oe_r;

endmodule
